param_updown_counter: RTL and testbench

- Parametrised synchronous up/down modulo-N counter with parallel load, dual count enables and cascadable carry/borrow output.
- Successor to the fixed 4-bit binary counter: adds a width parameter, an arbitrary modulus, count direction and a one-cycle wrap pulse.
- Used as a building block for timers, BCD digit chains and clock dividers in the lab designs.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/counter_tc_detect.sv | 31 +++
 rtl/param_updown_counter.sv | 87 ++++++++
 tb/tb_param_updown_counter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the up/down counter family.
//   DIR_UP / DIR_DOWN : encodings of the UD direction input
//   clog2             : constant function for derived widths
//   next_count        : wrapped modulo successor/predecessor of a count value
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned next_count(input int unsigned q,
                                             input logic        up,
                                             input int unsigned modulus);
    if (up == DIR_UP) return (q == modulus - 1) ? 0 : q + 1;
    else              return (q == 0) ? modulus - 1 : q - 1;
  endfunction

endpackage

// File: rtl/counter_tc_detect.sv
// counter_tc_detect: combinational terminal-count detector.
//   q      : current count (WIDTH bits)
//   ctt    : count enable T, gates co
//   ud     : direction, 1 = up, 0 = down
//   at_max : q == MODULUS-1
//   at_min : q == 0
//   co     : ctt & (ud ? at_max : at_min), the cascade carry/borrow
module counter_tc_detect
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             ctt,
  input  logic             ud,
  output logic             at_max,
  output logic             at_min,
  output logic             co
);

  // One extra bit so MODULUS = 2^WIDTH does not overflow the constant.
  localparam logic [WIDTH:0] MAX_VAL = (WIDTH + 1)'(MODULUS - 1);

  always_comb begin
    at_max = ({1'b0, q} == MAX_VAL);
    at_min = (q == '0);
    co     = ctt & ((ud == DIR_UP) ? at_max : at_min);
  end

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: synchronous up/down modulo-MODULUS counter with
// active-low parallel load, dual count enables and cascadable Co.
//   CP   : clock, rising edge
//   CR   : synchronous reset, active-high
//   CTP  : count enable P
//   CTT  : count enable T, also gates Co
//   LD   : synchronous parallel load, active-low (D >= MODULUS clamps)
//   UD   : direction, 1 = up, 0 = down
//   D    : load value
//   Q    : registered count
//   Co   : combinational terminal-count carry/borrow
//   Wrap : registered one-cycle pulse after a wrapping count edge
// Build option: COUNTER_SATURATE_EN makes counting saturate at the range
// ends instead of wrapping; Wrap is then tied to 0.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             CTP,
  input  logic             CTT,
  input  logic             LD,
  input  logic             UD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Co,
  output logic             Wrap
);

  localparam int unsigned    MOD_BITS = clog2(MODULUS);
  localparam logic [WIDTH:0] MOD_W    = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_VAL  = (WIDTH + 1)'(MODULUS - 1);

  if (WIDTH < 1 || MODULUS < 2 || MOD_BITS > WIDTH) begin : g_bad_params
    $error("param_updown_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
  end

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_q;
  logic             wrap_evt;

  counter_tc_detect #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .q      (Q),
    .ctt    (CTT),
    .ud     (UD),
    .at_max (at_max),
    .at_min (at_min),
    .co     (Co)
  );

  always_comb begin
    load_val = ({1'b0, D} >= MOD_W) ? MAX_VAL[WIDTH-1:0] : D;
`ifdef COUNTER_SATURATE_EN
    wrap_evt = 1'b0;
    if (UD == DIR_UP) next_q = at_max ? Q : Q + 1'b1;
    else              next_q = at_min ? Q : Q - 1'b1;
`else
    // A count edge wraps exactly when it leaves the terminal value.
    wrap_evt = (UD == DIR_UP) ? at_max : at_min;
    next_q   = WIDTH'(next_count(32'(Q), UD, 32'(MODULUS)));
`endif
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      Q    <= '0;
      Wrap <= 1'b0;
    end else if (!LD) begin
      Q    <= load_val;
      Wrap <= 1'b0;
    end else if (CTP && CTT) begin
      Q    <= next_q;
      Wrap <= wrap_evt;
    end else begin
      Wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter: a stimulus process drives
// vectors and queues the expected post-edge outputs; a monitor pops and
// compares them at each falling edge.
module tb_param_updown_counter;

  logic       CP = 1'b0;
  logic       CR = 1'b0, CTP = 1'b0, CTT = 1'b0, LD = 1'b1, UD = 1'b1;
  logic [3:0] D = '0;

  logic [3:0] q10, q16, q_s0, q_s1;
  logic       co10, co16, co_s0, co_s1;
  logic       w10, w16, w_s0, w_s1;

  always #5 CP = ~CP;

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .CP(CP), .CR(CR), .CTP(CTP), .CTT(CTT), .LD(LD), .UD(UD), .D(D),
    .Q(q10), .Co(co10), .Wrap(w10));

  param_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .CP(CP), .CR(CR), .CTP(CTP), .CTT(CTT), .LD(LD), .UD(UD), .D(D),
    .Q(q16), .Co(co16), .Wrap(w16));

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) stage0 (
    .CP(CP), .CR(CR), .CTP(CTP), .CTT(CTT), .LD(LD), .UD(UD), .D(D),
    .Q(q_s0), .Co(co_s0), .Wrap(w_s0));

  param_updown_counter #(.WIDTH(4), .MODULUS(10)) stage1 (
    .CP(CP), .CR(CR), .CTP(CTP), .CTT(co_s0), .LD(LD), .UD(UD), .D(D),
    .Q(q_s1), .Co(co_s1), .Wrap(w_s1));

  // sel: 0 = modulus-10 unit, 1 = modulus-16 unit, 2 = cascade {s1,s0}
  typedef struct {
    string      name;
    int         sel;
    logic [7:0] q;
    logic       co;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: one expectation per clock, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge CP);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        case (e.sel)
          0: begin
            cmp({e.name, ".q"},    int'(q10),  int'(e.q));
            cmp({e.name, ".co"},   int'(co10), int'(e.co));
            cmp({e.name, ".wrap"}, int'(w10),  int'(e.wrap));
          end
          1: begin
            cmp({e.name, ".q"},    int'(q16),  int'(e.q));
            cmp({e.name, ".co"},   int'(co16), int'(e.co));
            cmp({e.name, ".wrap"}, int'(w16),  int'(e.wrap));
          end
          default: begin
            cmp({e.name, ".q"},    int'({q_s1, q_s0}), int'(e.q));
            cmp({e.name, ".co0"},  int'(co_s0),        int'(e.co));
            cmp({e.name, ".wrap0"}, int'(w_s0),        int'(e.wrap));
          end
        endcase
      end
    end
  end

  // Apply one vector, clock it, queue the expected post-edge outputs.
  task automatic step(input string nm, input logic cr, input logic ctp,
                      input logic ctt, input logic ld, input logic ud,
                      input logic [3:0] d, input int sel,
                      input logic [7:0] eq, input logic eco, input logic ewrap);
    exp_t e;
    CR = cr; CTP = ctp; CTT = ctt; LD = ld; UD = ud; D = d;
    @(posedge CP);
    #1;
    e.name = nm; e.sel = sel; e.q = eq; e.co = eco; e.wrap = ewrap;
    exp_q.push_back(e);
    @(negedge CP);
    #1;
  endtask

  initial begin
    int ev, s0, s1;
    repeat (2) @(negedge CP);
    #1;

    // Reset, then count up 10 edges on the modulus-10 unit.
    step("rst", 1, 0, 0, 1, 1, 4'd0, 0, 8'd0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      ev = SAT ? ((k > 9) ? 9 : k) : (k % 10);
      step($sformatf("up%0d", k), 0, 1, 1, 1, 1, 4'd0, 0, 8'(ev),
           ev == 9, !SAT && k == 10);
    end

    // Load 2 then count down through the wrap.
    step("ld2",   0, 1, 1, 0, 0, 4'd2, 0, 8'd2, 0, 0);
    step("dn1",   0, 1, 1, 1, 0, 4'd0, 0, 8'd1, 0, 0);
    step("dn0",   0, 1, 1, 1, 0, 4'd0, 0, 8'd0, 1, 0);
    step("dnwrap", 0, 1, 1, 1, 0, 4'd0, 0, SAT ? 8'd0 : 8'd9, SAT, !SAT);
    step("dnpost", 0, 0, 1, 1, 0, 4'd0, 0, SAT ? 8'd0 : 8'd9, SAT, 0);

    // Load clamp beats counting; reset beats load.
    step("ldclamp", 0, 1, 1, 0, 1, 4'd12, 0, 8'd9, 1, 0);
    step("rstld",   1, 1, 1, 0, 1, 4'd5,  0, 8'd0, 0, 0);
    step("ld15",    0, 0, 0, 0, 1, 4'd15, 0, 8'd9, 0, 0);

    // Enables: hold with either enable low; Co follows CTT and UD only.
    step("ctt0", 0, 1, 0, 1, 1, 4'd0, 0, 8'd9, 0, 0);
    step("ctp0", 0, 0, 1, 1, 1, 4'd0, 0, 8'd9, 1, 0);
    step("udflip", 0, 0, 1, 1, 0, 4'd0, 0, 8'd9, 0, 0);
    step("ld0",  0, 0, 1, 0, 0, 4'd0, 0, 8'd0, 1, 0);

    // Modulus-16 unit: plain binary counter.
    step("b_rst", 1, 0, 0, 1, 1, 4'd0, 1, 8'd0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      ev = SAT ? ((k > 15) ? 15 : k) : (k % 16);
      step($sformatf("bin%0d", k), 0, 1, 1, 1, 1, 4'd0, 1, 8'(ev),
           ev == 15, !SAT && k == 16);
    end

    // Cascade: stage1 counts on stage0's Co.
    step("c_rst", 1, 0, 0, 1, 1, 4'd0, 2, 8'h00, 0, 0);
    for (int k = 1; k <= 25; k++) begin
      if (SAT) begin
        s0 = (k > 9) ? 9 : k;
        s1 = (k > 9) ? (((k - 9) > 9) ? 9 : (k - 9)) : 0;
      end else begin
        s0 = k % 10;
        s1 = (k / 10) % 10;
      end
      step($sformatf("cas%0d", k), 0, 1, 1, 1, 1, 4'd0, 2,
           {4'(s1), 4'(s0)}, s0 == 9, !SAT && s0 == 0);
    end
    if (!SAT) cmp("cascade_final", int'({q_s1, q_s0}), 8'h25);

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 2000;
    while (!(stim_done && exp_q.size() == 0) && budget > 0) begin
      @(negedge CP);
      budget--;
    end
    #2;
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
